life_manager: RTL
=================

// Module: life_manager
// PURPOSE
//  Consumes the registered collision flag from the collision detector. Runs the
//  per-life sequence: lose a life, freeze and blink Pac-Man, respawn, then grant
//  a short invincibility window. Drives game-over.
//  Sits between the collision detector and the sprite/ghost movement blocks.
//  Those blocks obey freeze/respawn; the display reads lives/game_over/visible.
// PARAMETERS
//  LIVES_INIT    3   lives loaded at start/restart
//  LIFE_W        3   width of lives counter; LIVES_INIT < 2**LIFE_W
//  DEATH_FRAMES  60  frames spent in DYING (freeze + blink), >= 1
//  GRACE_FRAMES  90  frames of invincibility after respawn, >= 1
//  BLINK_HALF    8   frames per visible/invisible half-period while DYING, >= 1
//  CNT_W         8   timer width; must hold max(DEATH_FRAMES, GRACE_FRAMES)
// PORTS
//  frame_clk      in   1       clock, one tick per video frame
//  reset          in   1       synchronous, active-high
//  died           in   1       collision level; high while Pac-Man overlaps a ghost
//  start          in   1       start/restart key, level; rising edge acts
//  lives          out  LIFE_W  remaining lives
//  freeze         out  1       1 = all movement blocks hold position
//  respawn        out  1       1-cycle pulse: movement blocks reload start positions
//  invincible     out  1       1 during grace window; collisions ignored
//  pacman_visible out  1       sprite enable (blinks while DYING)
//  game_over      out  1       1 in GAME_OVER state
// BEHAVIOUR
//  Reset: state=IDLE, lives=LIVES_INIT, freeze=1, respawn=0, invincible=0,
//   pacman_visible=1, game_over=0, timers=0, start_q=0.
//   Reset wins over every other input on the same edge.
//  start_rise = start & ~start_q; start_q is registered every cycle.
//  States (all outputs registered; each takes effect the edge after its cause):
//   IDLE: freeze=1. On start_rise: lives<=LIVES_INIT, go to RESPAWN.
//   RESPAWN: exactly one cycle. respawn=1, freeze=1.
//    grace timer<=GRACE_FRAMES-1. Next state is PLAY.
//   PLAY: freeze=0. invincible=1 while grace timer != 0, decrementing once per frame.
//    On died & ~invincible: lives<=lives-1 (saturate at 0).
//    Death timer<=DEATH_FRAMES-1, blink counter cleared. Next state is DYING.
//    died while invincible is ignored, and does not extend the grace window.
//    start_rise is ignored in PLAY.
//   DYING: freeze=1, invincible=0. died and start are ignored.
//    pacman_visible toggles every BLINK_HALF frames, starting visible.
//    When death timer==0: if lives==0 go to GAME_OVER, else go to RESPAWN.
//    DEATH_FRAMES=N gives exactly N cycles in DYING.
//   GAME_OVER: freeze=1, game_over=1, pacman_visible=0.
//    On start_rise: lives<=LIVES_INIT, go to RESPAWN.
//  pacman_visible=1 in IDLE, RESPAWN and PLAY.
//  game_over=0 in every state except GAME_OVER.
//  died held high across the RESPAWN->PLAY transition does not kill,
//   because invincible is already 1 on entry to PLAY.
//  Counters never wrap. The grace timer holds at 0.
//   The death timer is only decremented in DYING.
//  Only one life is lost per DYING episode, regardless of how long died stays high.
// STRUCTURE
//  game_pkg (shared): typedef enum logic[2:0] life_state_t
//   {LS_IDLE, LS_RESPAWN, LS_PLAY, LS_DYING, LS_GAME_OVER}.
//   Default LIVES_INIT/DEATH_FRAMES/GRACE_FRAMES constants are reused by HUD and ghost AI.
//  Sub-module frame_timer #(CNT_W): load, load_val, en -> count, zero.
//   Saturating down-counter. Instantiate twice: death and grace.
//   The blink counter is a local counter.
// TESTING
//  T1 reset, start pulse -> RESPAWN 1 cycle (respawn=1), then PLAY.
//   In PLAY: freeze=0, lives=3, invincible=1 for exactly 90 cycles.
//  T2 after grace, died=1 for 5 cycles -> lives 3->2 once.
//   DYING for 60 cycles with visible toggling every 8. Then respawn pulse, then PLAY.
//  T3 died=1 during grace (cycle 10 of 90) -> no state change, lives unchanged.
//   invincible still drops at cycle 90.
//  T4 three deaths from LIVES_INIT=3 -> lives=0 after third.
//   After 60 DYING cycles: GAME_OVER, game_over=1, visible=0. start held high -> no restart.
//   Release then press -> lives=3, respawn pulse.
//  T5 reset asserted mid-DYING (cycle 30) -> next edge: IDLE, lives=3, freeze=1, visible=1.
//   No respawn pulse.
//  T6 died and start rising together in PLAY (not invincible) -> DYING entered.
//   start is ignored; lives decremented by exactly 1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-wide types and default constants.
// Used by the life manager, the HUD and the ghost AI.
package game_pkg;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_RESPAWN,
        LS_PLAY,
        LS_DYING,
        LS_GAME_OVER
    } life_state_t;

    localparam int GP_LIVES_INIT   = 3;
    localparam int GP_LIFE_W       = 3;
    localparam int GP_DEATH_FRAMES = 60;
    localparam int GP_GRACE_FRAMES = 90;
    localparam int GP_BLINK_HALF   = 8;
    localparam int GP_CNT_W        = 8;

endpackage

// File: rtl/frame_timer.sv
// Saturating frame down-counter with synchronous load.
// Load has priority over the decrement; the count holds at zero.
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             frame_clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/life_manager.sv
// Per-life sequencing: death freeze/blink, respawn pulse,
// invincibility window and game-over.
module life_manager
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = GP_LIVES_INIT,
    parameter int LIFE_W       = GP_LIFE_W,
    parameter int DEATH_FRAMES = GP_DEATH_FRAMES,
    parameter int GRACE_FRAMES = GP_GRACE_FRAMES,
    parameter int BLINK_HALF   = GP_BLINK_HALF,
    parameter int CNT_W        = GP_CNT_W
) (
    input  logic              frame_clk,
    input  logic              reset,
    input  logic              died,
    input  logic              start,
    output logic [LIFE_W-1:0] lives,
    output logic              freeze,
    output logic              respawn,
    output logic              invincible,
    output logic              pacman_visible,
    output logic              game_over
);

    localparam int BLINK_W = $clog2(BLINK_HALF + 1);

    life_state_t       state_q, state_d;
    logic [LIFE_W-1:0] lives_q, lives_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic              start_q;
    logic              start_rise;
    logic              kill;
    logic              freeze_q, freeze_d;
    logic              respawn_q, respawn_d;
    logic              invincible_q, invincible_d;
    logic              visible_q, visible_d;
    logic              game_over_q, game_over_d;

    logic              death_zero;
    logic              grace_zero;
    logic [CNT_W-1:0]  death_cnt_unused;
    logic [CNT_W-1:0]  grace_cnt_unused;

    assign start_rise = start & ~start_q;
    assign kill       = died & ~invincible_q;

    frame_timer #(.CNT_W(CNT_W)) u_death_timer (
        .frame_clk (frame_clk),
        .reset     (reset),
        .load      ((state_q == LS_PLAY) && kill),
        .load_val  (CNT_W'(DEATH_FRAMES - 1)),
        .en        (state_q == LS_DYING),
        .count     (death_cnt_unused),
        .zero      (death_zero)
    );

    frame_timer #(.CNT_W(CNT_W)) u_grace_timer (
        .frame_clk (frame_clk),
        .reset     (reset),
        .load      (state_q == LS_RESPAWN),
        .load_val  (CNT_W'(GRACE_FRAMES - 1)),
        .en        (state_q == LS_PLAY),
        .count     (grace_cnt_unused),
        .zero      (grace_zero)
    );

    always_ff @(posedge frame_clk) begin
        if (reset) begin
            state_q      <= LS_IDLE;
            lives_q      <= LIFE_W'(LIVES_INIT);
            blink_q      <= '0;
            start_q      <= 1'b0;
            freeze_q     <= 1'b1;
            respawn_q    <= 1'b0;
            invincible_q <= 1'b0;
            visible_q    <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            blink_q      <= blink_d;
            start_q      <= start;
            freeze_q     <= freeze_d;
            respawn_q    <= respawn_d;
            invincible_q <= invincible_d;
            visible_q    <= visible_d;
            game_over_q  <= game_over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        unique case (state_q)
            LS_IDLE, LS_GAME_OVER: begin
                if (start_rise) begin
                    lives_d = LIFE_W'(LIVES_INIT);
                    state_d = LS_RESPAWN;
                end
            end
            LS_RESPAWN: state_d = LS_PLAY;
            LS_PLAY: begin
                if (kill) begin
                    lives_d = (lives_q == '0) ? '0 : lives_q - LIFE_W'(1);
                    state_d = LS_DYING;
                end
            end
            LS_DYING: begin
                if (death_zero) begin
                    state_d = (lives_q == '0) ? LS_GAME_OVER : LS_RESPAWN;
                end
            end
            default: state_d = LS_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with state_q.
    always_comb begin
        freeze_d     = (state_d != LS_PLAY);
        respawn_d    = (state_d == LS_RESPAWN);
        game_over_d  = (state_d == LS_GAME_OVER);
        invincible_d = (state_d == LS_PLAY) &&
                       ((state_q == LS_RESPAWN) || !grace_zero);
        blink_d      = '0;
        visible_d    = 1'b1;
        if ((state_d == LS_DYING) && (state_q == LS_DYING)) begin
            if (blink_q == BLINK_W'(BLINK_HALF - 1)) begin
                blink_d   = '0;
                visible_d = ~visible_q;
            end else begin
                blink_d   = blink_q + BLINK_W'(1);
                visible_d = visible_q;
            end
        end else if (state_d == LS_GAME_OVER) begin
            visible_d = 1'b0;
        end
    end

    assign lives          = lives_q;
    assign freeze         = freeze_q;
    assign respawn        = respawn_q;
    assign invincible     = invincible_q;
    assign pacman_visible = visible_q;
    assign game_over      = game_over_q;

endmodule
